// File: rtl/prf_slice_read_arbiter_pkg.sv
// Shared types and constants for the byte-sliced PRF read arbiter and its
// downstream consumers (the bypass network aligns on PRF_RD_STAGES).
package prf_slice_read_arbiter_pkg;

  localparam int NUM_REQ           = 4;
  localparam int NUM_PORTS         = 2;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int REQ_ID_W          = 2;
  localparam int PRF_RD_STAGES     = 3;

  typedef struct packed {
    logic                         valid;
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
    logic [REQ_ID_W-1:0]          lane;
  } prfRdPkt;

  // Lane index arithmetic that wraps modulo NUM_REQ.
  function automatic logic [REQ_ID_W-1:0] lane_wrap(input logic [REQ_ID_W-1:0] base,
                                                    input logic [REQ_ID_W-1:0] off);
    return REQ_ID_W'((int'(base) + int'(off)) % NUM_REQ);
  endfunction

endpackage

// File: rtl/prf_slice_read_arbiter_if.sv
// Request handshake and PRF slice-read bus of the read arbiter.
interface prf_slice_read_arbiter_if;
  import prf_slice_read_arbiter_pkg::*;

  logic                                        flush_i;
  logic [NUM_PORTS-1:0]                        port_en_i;
  logic [NUM_REQ-1:0]                          req_valid_i;
  logic [NUM_REQ-1:0][SIZE_PHYSICAL_LOG-1:0]   req_tag_i;
  logic [NUM_REQ-1:0]                          req_ready_o;
  logic [NUM_PORTS-1:0]                        s0_en_o;
  logic [NUM_PORTS-1:0][SIZE_PHYSICAL_LOG-1:0] s0_addr_o;
  logic [NUM_PORTS-1:0]                        s1_en_o;
  logic [NUM_PORTS-1:0][SIZE_PHYSICAL_LOG-1:0] s1_addr_o;
  logic [NUM_PORTS-1:0]                        s23_en_o;
  logic [NUM_PORTS-1:0][SIZE_PHYSICAL_LOG-1:0] s23_addr_o;
  logic [NUM_PORTS-1:0]                        rd_valid_o;
  logic [NUM_PORTS-1:0][SIZE_PHYSICAL_LOG-1:0] rd_tag_o;
  logic [NUM_PORTS-1:0][REQ_ID_W-1:0]          rd_lane_o;

  modport master (
    output flush_i, port_en_i, req_valid_i, req_tag_i,
    input  req_ready_o, s0_en_o, s0_addr_o, s1_en_o, s1_addr_o,
    input  s23_en_o, s23_addr_o, rd_valid_o, rd_tag_o, rd_lane_o
  );

  modport slave (
    input  flush_i, port_en_i, req_valid_i, req_tag_i,
    output req_ready_o, s0_en_o, s0_addr_o, s1_en_o, s1_addr_o,
    output s23_en_o, s23_addr_o, rd_valid_o, rd_tag_o, rd_lane_o
  );

endinterface

// File: rtl/prf_rr_picker.sv
// Round-robin picker: the k-th requesting lane scanned from i_rr_ptr takes
// the k-th enabled port in ascending port order.
module prf_rr_picker
  import prf_slice_read_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]                i_req,
  input  logic [REQ_ID_W-1:0]               i_rr_ptr,
  input  logic [NUM_PORTS-1:0]              i_port_en,
  output logic [NUM_PORTS-1:0][NUM_REQ-1:0] o_grant,
  output logic [NUM_REQ-1:0]                o_ready,
  output logic [REQ_ID_W-1:0]               o_rr_nxt
);

  logic [NUM_PORTS-1:0] w_used;
  logic [REQ_ID_W-1:0]  w_lane;
  logic                 w_found;

  // Scan lanes in rotated order, handing each requester the lowest unused enabled port.
  always_comb begin
    o_grant  = '0;
    o_ready  = '0;
    o_rr_nxt = i_rr_ptr;
    w_used   = '0;
    w_lane   = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_lane  = lane_wrap(i_rr_ptr, REQ_ID_W'(k));
      w_found = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (i_req[w_lane] && !w_found && i_port_en[p] && !w_used[p]) begin
          o_grant[p][w_lane] = 1'b1;
          o_ready[w_lane]    = 1'b1;
          w_used[p]          = 1'b1;
          w_found            = 1'b1;
          o_rr_nxt           = lane_wrap(w_lane, REQ_ID_W'(1));
        end else begin
          w_used[p] = w_used[p];
        end
      end
    end
  end

endmodule

// File: rtl/prf_slice_read_arbiter.sv
// Arbitrates lane read requests onto PRF read ports and walks each granted
// read through the three slice stages (slice 0, slice 1, slices 2/3).
module prf_slice_read_arbiter
  import prf_slice_read_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  prf_slice_read_arbiter_if.slave  bus
);

  logic [REQ_ID_W-1:0]               r_rr_ptr;
  prfRdPkt [NUM_PORTS-1:0]           r_s0;
  prfRdPkt [NUM_PORTS-1:0]           r_s1;
  prfRdPkt [NUM_PORTS-1:0]           r_s2;

  logic                              w_accept;
  logic [NUM_REQ-1:0]                w_req;
  logic [NUM_PORTS-1:0][NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0]                w_ready;
  logic [REQ_ID_W-1:0]               w_rr_nxt;
  prfRdPkt [NUM_PORTS-1:0]           w_s0_nxt;

  // No handshake can complete while in reset or during a flush cycle.
  assign w_accept = reset & ~bus.flush_i;
  assign w_req    = bus.req_valid_i & {NUM_REQ{w_accept}};

  prf_rr_picker u_picker (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .i_port_en (bus.port_en_i),
    .o_grant   (w_grant),
    .o_ready   (w_ready),
    .o_rr_nxt  (w_rr_nxt)
  );

  assign bus.req_ready_o = w_ready;

  // Build the stage-0 packet of each port from its granted lane.
  always_comb begin
    w_s0_nxt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int l = 0; l < NUM_REQ; l++) begin
        if (w_grant[p][l]) begin
          w_s0_nxt[p].valid = 1'b1;
          w_s0_nxt[p].tag   = bus.req_tag_i[l];
          w_s0_nxt[p].lane  = REQ_ID_W'(l);
        end else begin
          w_s0_nxt[p] = w_s0_nxt[p];
        end
      end
    end
  end

  // Stage pipeline and round-robin pointer; flush drops every in-flight valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_s0     <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
      r_s0     <= w_s0_nxt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_s1[p] <= '{valid: r_s0[p].valid & ~bus.flush_i, tag: r_s0[p].tag, lane: r_s0[p].lane};
        r_s2[p] <= '{valid: r_s1[p].valid & ~bus.flush_i, tag: r_s1[p].tag, lane: r_s1[p].lane};
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    assign bus.s0_en_o[p]    = r_s0[p].valid;
    assign bus.s0_addr_o[p]  = r_s0[p].tag;
    assign bus.s1_en_o[p]    = r_s1[p].valid;
    assign bus.s1_addr_o[p]  = r_s1[p].tag;
    assign bus.s23_en_o[p]   = r_s2[p].valid;
    assign bus.s23_addr_o[p] = r_s2[p].tag;
    assign bus.rd_valid_o[p] = r_s2[p].valid;
    assign bus.rd_tag_o[p]   = r_s2[p].tag;
    assign bus.rd_lane_o[p]  = r_s2[p].lane;
  end

endmodule

// File: tb/tb_prf_slice_read_arbiter.sv
// Randomized scoreboard bench for prf_slice_read_arbiter: a list-based
// arbitration model predicts grants and per-stage slice reads per port.
module tb_prf_slice_read_arbiter;
  import prf_slice_read_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prf_slice_read_arbiter_if bus();

  prf_slice_read_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         port;
    logic [6:0] tag;
    int         lane;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int cycles; int mask; int prob; int pen; int flush_pct; int fix_tag; int rst_at; int rst_len;
  } phase_t;
  phase_t ph[12];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  function automatic int find(input int due, input int port);
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].due == due && sb[i].port == port) return i;
    return -1;
  endfunction

  // Monitor: each cycle compare every stage of every port against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < NUM_PORTS; p++) begin
        int i0, i1, i2;
        i0 = find(cyc + 2, p);
        i1 = find(cyc + 1, p);
        i2 = find(cyc, p);
        chk("s0_en", 32'(bus.s0_en_o[p]), 32'(i0 >= 0));
        if (i0 >= 0) chk("s0_addr", 32'(bus.s0_addr_o[p]), 32'(sb[i0].tag));
        chk("s1_en", 32'(bus.s1_en_o[p]), 32'(i1 >= 0));
        if (i1 >= 0) chk("s1_addr", 32'(bus.s1_addr_o[p]), 32'(sb[i1].tag));
        chk("rd_valid", 32'(bus.rd_valid_o[p]), 32'(i2 >= 0));
        chk("s23_en", 32'(bus.s23_en_o[p]), 32'(i2 >= 0));
        if (i2 >= 0) begin
          chk("s23_addr", 32'(bus.s23_addr_o[p]), 32'(sb[i2].tag));
          chk("rd_tag", 32'(bus.rd_tag_o[p]), 32'(sb[i2].tag));
          chk("rd_lane", 32'(bus.rd_lane_o[p]), sb[i2].lane);
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due <= cyc) sb.delete(i);
    end
  end

  // Stimulus plus reference arbitration model.
  initial begin
    logic [3:0] hold;
    logic [3:0] rexp;
    logic [6:0] htag [4];
    logic [1:0] pen;
    int         rr_m;
    int         ports[$];
    int         k, last, l;

    ph[0]  = '{2,   15, 100, 3, 0,  0, 0, 2};
    ph[1]  = '{12,  15, 100, 3, 0,  0, -1, 0};
    ph[2]  = '{6,   0,  0,   3, 0,  0, -1, 0};
    ph[3]  = '{6,   4,  100, 3, 0,  1, -1, 0};
    ph[4]  = '{6,   0,  0,   3, 0,  0, -1, 0};
    ph[5]  = '{16,  15, 100, 3, 30, 0, -1, 0};
    ph[6]  = '{6,   0,  0,   3, 0,  0, -1, 0};
    ph[7]  = '{10,  10, 100, 2, 0,  0, -1, 0};
    ph[8]  = '{6,   0,  0,   3, 0,  0, -1, 0};
    ph[9]  = '{8,   15, 100, 3, 0,  0, 5, 1};
    ph[10] = '{220, 15, 50,  4, 5,  0, -1, 0};
    ph[11] = '{8,   0,  0,   3, 0,  0, -1, 0};

    hold = 4'b0000;
    rr_m = 0;
    for (int i = 0; i < 4; i++) htag[i] = 7'h00;
    reset           = 1'b0;
    bus.flush_i     = 1'b0;
    bus.port_en_i   = 2'b11;
    bus.req_valid_i = 4'b0000;
    bus.req_tag_i   = '0;

    for (int pi = 0; pi < 12; pi++) begin
      for (int c = 0; c < ph[pi].cycles; c++) begin
        @(posedge clk);
        #1;
        reset       = (c >= ph[pi].rst_at && c < ph[pi].rst_at + ph[pi].rst_len) ? 1'b0 : 1'b1;
        bus.flush_i = (int'($urandom % 100) < ph[pi].flush_pct) ? 1'b1 : 1'b0;
        pen         = (ph[pi].pen == 4) ? 2'($urandom_range(0, 3)) : 2'(ph[pi].pen);
        bus.port_en_i = pen;
        for (int i = 0; i < 4; i++) begin
          if (!hold[i] && ph[pi].mask[i] && int'($urandom % 100) < ph[pi].prob) begin
            hold[i] = 1'b1;
            htag[i] = (ph[pi].fix_tag != 0) ? 7'h2A : 7'($urandom);
          end
        end
        bus.req_valid_i = hold;
        for (int i = 0; i < 4; i++) bus.req_tag_i[i] = htag[i];

        @(negedge clk);
        #2;
        if (pi == 1 && c == 0) begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            chk("rst_s0_addr", 32'(bus.s0_addr_o[p]), 32'd0);
            chk("rst_s1_addr", 32'(bus.s1_addr_o[p]), 32'd0);
            chk("rst_s23_addr", 32'(bus.s23_addr_o[p]), 32'd0);
            chk("rst_rd_tag", 32'(bus.rd_tag_o[p]), 32'd0);
            chk("rst_rd_lane", 32'(bus.rd_lane_o[p]), 32'd0);
          end
        end

        rexp = 4'b0000;
        if (!reset || bus.flush_i) begin
          if (!reset) rr_m = 0;
          for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due > cyc) sb.delete(i);
        end else begin
          ports.delete();
          for (int p = 0; p < NUM_PORTS; p++)
            if (pen[p]) ports.push_back(p);
          k = 0;
          last = -1;
          for (int i = 0; i < 4; i++) begin
            l = (rr_m + i) % 4;
            if (hold[l] && k < ports.size()) begin
              rexp[l] = 1'b1;
              sb.push_back('{cyc + PRF_RD_STAGES, ports[k], htag[l], l});
              k++;
              last = l;
            end
          end
          if (last >= 0) rr_m = (last + 1) % 4;
        end
        chk("req_ready", 32'(bus.req_ready_o), 32'(rexp));
        hold = hold & ~rexp;
      end
    end

    @(negedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
